// File: rtl/matmul_seq_ctrl_pkg.sv
// rtl/matmul_seq_ctrl_pkg.sv - shared widths, FSM state encoding and strobe helper for the matmul sequencer
package matmul_seq_ctrl_pkg;
   localparam int DW      = 8;
   localparam int BW      = 32;
   localparam int MAX_DIM = BW / DW;
   localparam int SW      = $clog2(3 * MAX_DIM);
   localparam int AW      = $clog2(MAX_DIM);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WB    = 3'd4,
      ST_DONE  = 3'd5
   } seq_state_e;

   // Low (dim_m+1) element strobes set.
   function automatic logic [MAX_DIM-1:0] col_mask(input logic [AW-1:0] dim_m);
      logic [MAX_DIM-1:0] mask;
      for (int i = 0; i < MAX_DIM; i++) begin
         mask[i] = (i <= int'(dim_m));
      end
      return mask;
   endfunction
endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// rtl/matmul_seq_ctrl_if.sv - array control and result-file write port driven by the sequencer
interface matmul_seq_ctrl_if;
   import matmul_seq_ctrl_pkg::*;

   logic               sa_clear;
   logic               sa_step;
   logic [SW-1:0]      step_idx;
   logic               res_ena;
   logic [AW-1:0]      res_addr;
   logic [MAX_DIM-1:0] res_pstrb;

   modport master (
      output sa_clear, sa_step, step_idx, res_ena, res_addr, res_pstrb
   );

   modport slave (
      input sa_clear, sa_step, step_idx, res_ena, res_addr, res_pstrb
   );
endinterface

// File: rtl/matmul_seq_ctrl_seq_counter.sv
// rtl/matmul_seq_ctrl_seq_counter.sv - generic up-counter with clear, enable and terminal-count flag
module matmul_seq_ctrl_seq_counter #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         reset_ni,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == last_i);
endmodule

// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - sequences clear, skewed feed, drain and result write-back for one matmul job
module matmul_seq_ctrl
   import matmul_seq_ctrl_pkg::*;
#(
   parameter int PIPE_LAT = 1
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [AW-1:0]     dim_n_i,
   input  logic [AW-1:0]     dim_k_i,
   input  logic [AW-1:0]     dim_m_i,
   output logic              busy_o,
   output logic              done_o,
   matmul_seq_ctrl_if.master arr_if
);
   localparam int DLW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [DLW-1:0] DRAIN_LAST = DLW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

   seq_state_e         state_q, state_d;
   logic [AW-1:0]      dn_q, dn_d, dk_q, dk_d, dm_q, dm_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               clear_q, clear_d, step_q, step_d, ena_q, ena_d;
   logic [MAX_DIM-1:0] pstrb_q, pstrb_d;

   logic               feed_clr, feed_en, feed_tc;
   logic               drain_clr, drain_en, drain_tc;
   logic               wb_clr, wb_en, wb_tc;
   logic [SW-1:0]      feed_cnt, feed_last;
   logic [DLW-1:0]     drain_cnt;
   logic [AW-1:0]      wb_cnt;

   // S-1 = (n+k+m-2)-1 expressed on the minus-one encoded dims.
   assign feed_last = SW'(dn_q) + SW'(dk_q) + SW'(dm_q);

   always_comb begin
      state_d = state_q;
      dn_d    = dn_q;
      dk_d    = dk_q;
      dm_d    = dm_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_CLEAR;
               dn_d    = dim_n_i;
               dk_d    = dim_k_i;
               dm_d    = dim_m_i;
            end
         end
         ST_CLEAR: state_d = ST_FEED;
         ST_FEED:  if (feed_tc) state_d = (PIPE_LAT == 0) ? ST_WB : ST_DRAIN;
         ST_DRAIN: if (drain_tc) state_d = ST_WB;
         ST_WB:    if (wb_tc) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (abort_i && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end
   end

   // Outputs are decoded from the next state so every port comes straight off a flop.
   always_comb begin
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
      clear_d   = (state_d == ST_CLEAR);
      step_d    = (state_d == ST_FEED) || (state_d == ST_DRAIN);
      ena_d     = (state_d == ST_WB);
      pstrb_d   = ena_d ? col_mask(dm_q) : '0;
      feed_clr  = !step_d;
      feed_en   = (state_q == ST_FEED) && (state_d == ST_FEED);
      drain_clr = (state_d != ST_DRAIN);
      drain_en  = (state_q == ST_DRAIN) && (state_d == ST_DRAIN);
      wb_clr    = !ena_d;
      wb_en     = (state_q == ST_WB) && (state_d == ST_WB);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q <= ST_IDLE;
         dn_q    <= '0;
         dk_q    <= '0;
         dm_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clear_q <= 1'b0;
         step_q  <= 1'b0;
         ena_q   <= 1'b0;
         pstrb_q <= '0;
      end else begin
         state_q <= state_d;
         dn_q    <= dn_d;
         dk_q    <= dk_d;
         dm_q    <= dm_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         clear_q <= clear_d;
         step_q  <= step_d;
         ena_q   <= ena_d;
         pstrb_q <= pstrb_d;
      end
   end

   matmul_seq_ctrl_seq_counter #(.W(SW)) u_feed_cnt (
      .clk_i(clk_i), .reset_ni(reset_ni), .clr_i(feed_clr), .en_i(feed_en),
      .last_i(feed_last), .cnt_o(feed_cnt), .tc_o(feed_tc)
   );

   matmul_seq_ctrl_seq_counter #(.W(DLW)) u_drain_cnt (
      .clk_i(clk_i), .reset_ni(reset_ni), .clr_i(drain_clr), .en_i(drain_en),
      .last_i(DRAIN_LAST), .cnt_o(drain_cnt), .tc_o(drain_tc)
   );

   matmul_seq_ctrl_seq_counter #(.W(AW)) u_wb_cnt (
      .clk_i(clk_i), .reset_ni(reset_ni), .clr_i(wb_clr), .en_i(wb_en),
      .last_i(dn_q), .cnt_o(wb_cnt), .tc_o(wb_tc)
   );

   logic unused_drain;
   assign unused_drain = ^drain_cnt;

   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign arr_if.sa_clear  = clear_q;
   assign arr_if.sa_step   = step_q;
   assign arr_if.step_idx  = feed_cnt;
   assign arr_if.res_ena   = ena_q;
   assign arr_if.res_addr  = wb_cnt;
   assign arr_if.res_pstrb = pstrb_q;
endmodule
